// File: rtl/calc_mem_pkg.sv
// calc_mem_pkg
//   Shared definitions for the calculator Memory request path: the sequencer
//   state encoding and the Memory rw encoding used by the Memory block,
//   the controller and the benches.
package calc_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_REQ  = 2'd2,
      RD_WAIT = 2'd3
   } mem_ctrl_state_t;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/calc_mem_ctrl.sv
// calc_mem_ctrl
//   Request sequencer in front of the calculator Memory block. Takes one
//   read/write request at a time and drives a one-cycle Memory strobe.
//   Read data is captured and returned with a one-cycle rd_valid pulse.
//   An internal auto-increment pointer lets a producer stream into
//   consecutive words.
//
//   Handshake: a request transfers on a posedge where req_valid && req_ready.
//   req_ready is high only in IDLE. Every request field is captured on that
//   edge, so the requester may change req_* freely afterwards.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_rw, req_auto       1 = write / 1 = use the internal pointer as address
//   req_addr, req_data     explicit address and write data
//   ptr_clr                synchronous clear of the auto-increment pointer
//   mem_din/addr/rw/valid  Memory port; mem_valid is a one-cycle strobe
//   mem_dout               Memory read data, valid the cycle after a read strobe
//   rd_data, rd_valid      captured read data and its one-cycle update pulse
//   ptr                    current auto-increment pointer
//   state                  current FSM state (debug visibility)
module calc_mem_ctrl
   import calc_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic              req_auto,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic              ptr_clr,
   output logic [DATA_W-1:0] mem_din,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rw,
   output logic              mem_valid,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] ptr,
   output mem_ctrl_state_t   state
);

   logic accept;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && (state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         mem_din   <= '0;
         mem_addr  <= '0;
         mem_rw    <= MEM_RD;
         mem_valid <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         ptr       <= '0;
      end else begin
         // Strobes default low; only the accept edge raises mem_valid.
         mem_valid <= 1'b0;
         rd_valid  <= 1'b0;

         // A clear coinciding with an accepted auto request: the request
         // uses address 0, so the pointer moves past it to 1.
         if (ptr_clr)
            ptr <= (accept && req_auto) ? ADDR_W'(1) : '0;
         else if (accept && req_auto)
            ptr <= ptr + 1'b1;

         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_addr  <= req_auto ? (ptr_clr ? '0 : ptr) : req_addr;
                  mem_rw    <= req_rw;
                  mem_valid <= 1'b1;
                  if (req_rw == MEM_WR) begin
                     mem_din <= req_data;
                     state   <= WR;
                  end else begin
                     state   <= RD_REQ;
                  end
               end
            end
            WR:      state <= IDLE;
            RD_REQ:  state <= RD_WAIT;
            RD_WAIT: begin
               rd_data  <= mem_dout;
               rd_valid <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_mem_ctrl.sv
// tb_calc_mem_ctrl
//   Directed bench for calc_mem_ctrl with a behavioural Memory attached to
//   the Memory port. Expected read data comes from a bench-side shadow of
//   the writes issued; the pointer is tracked by a bench-side counter.
module tb_calc_mem_ctrl;
   import calc_mem_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic              req_auto;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              ptr_clr;
   logic [DATA_W-1:0] mem_din;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rw;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_dout;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [ADDR_W-1:0] ptr;
   mem_ctrl_state_t   state;

   int tests_run;
   int tests_failed;
   int overlap_cnt;

   logic [DATA_W-1:0] mem     [256];
   logic [DATA_W-1:0] exp_mem [256];
   logic [DATA_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] ptr_m;

   calc_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_auto  (req_auto),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .ptr_clr   (ptr_clr),
      .mem_din   (mem_din),
      .mem_addr  (mem_addr),
      .mem_rw    (mem_rw),
      .mem_valid (mem_valid),
      .mem_dout  (mem_dout),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .ptr       (ptr),
      .state     (state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural Memory ----------------
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         exp_mem[i] = '0;
      end
      mem_dout = '0;
   end

   always @(posedge clk) begin
      if (mem_valid) begin
         if (mem_rw == MEM_WR) mem[mem_addr] <= mem_din;
         else                  mem_dout      <= mem[mem_addr];
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Read-return scoreboard and strobe-overlap monitor.
   always @(negedge clk) begin
      if (reset) begin
         if (rd_valid && mem_valid) overlap_cnt++;
         if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
            else                   check("rd_data_sb", rd_data, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   // Presents one request, waits (bounded) for acceptance, then scrambles the
   // req_* inputs to show they are not sampled after acceptance.
   task automatic send(input logic rw, input logic auto_m,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                       input logic clr, input logic track);
      int n;
      logic [ADDR_W-1:0] eff;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("ready_timeout", {31'b0, req_ready}, 1);
         return;
      end
      req_valid = 1'b1;
      req_rw    = rw;
      req_auto  = auto_m;
      req_addr  = addr;
      req_data  = data;
      ptr_clr   = clr;
      eff = auto_m ? (clr ? 8'h00 : ptr_m) : addr;
      if (auto_m)   ptr_m = clr ? 8'h01 : ptr_m + 8'h01;
      else if (clr) ptr_m = 8'h00;
      if (rw)         exp_mem[eff] = data;
      else if (track) exp_q.push_back(exp_mem[eff]);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      ptr_clr   = 1'b0;
      req_rw    = ~rw;
      req_auto  = ~auto_m;
      req_addr  = ~addr;
      req_data  = ~data;
      check("acc_mem_valid", {31'b0, mem_valid}, 1);
      check("acc_mem_rw", {31'b0, mem_rw}, {31'b0, rw});
      check("acc_mem_addr", {24'b0, mem_addr}, {24'b0, eff});
      check("acc_ptr", {24'b0, ptr}, {24'b0, ptr_m});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      overlap_cnt  = 0;
      ptr_m        = 8'h00;

      // 1. reset held with a request pending
      reset     = 1'b0;
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_auto  = 1'b0;
      req_addr  = 8'h09;
      req_data  = 32'h55;
      ptr_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, req_ready}, 1);
      check("rst_state", {30'b0, state}, {30'b0, IDLE});
      check("rst_mem_valid", {31'b0, mem_valid}, 0);
      check("rst_mem_rw", {31'b0, mem_rw}, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_mem_addr", {24'b0, mem_addr}, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_valid", {31'b0, rd_valid}, 0);
      check("rst_ptr", {24'b0, ptr}, 0);
      @(negedge clk);
      reset = 1'b1;
      exp_mem[9] = 32'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rel_mem_valid", {31'b0, mem_valid}, 1);
      check("rel_mem_addr", {24'b0, mem_addr}, 9);
      check("rel_mem_din", mem_din, 32'h55);
      check("rel_state", {30'b0, state}, {30'b0, WR});

      // 2. explicit write then read of address 4
      send(1'b1, 1'b0, 8'h04, 32'h7, 1'b0, 1'b1);
      check("wr_din", mem_din, 32'h7);
      check("wr_ready_low", {31'b0, req_ready}, 0);
      @(posedge clk); #1;
      check("wr_strobe_end", {31'b0, mem_valid}, 0);
      check("wr_addr_hold", {24'b0, mem_addr}, 4);
      check("wr_ready_back", {31'b0, req_ready}, 1);
      send(1'b0, 1'b0, 8'h04, 32'h0, 1'b0, 1'b1);
      check("rd_din_hold", mem_din, 32'h7);
      @(posedge clk); #1;
      check("rd_wait_state", {30'b0, state}, {30'b0, RD_WAIT});
      check("rd_wait_valid", {31'b0, rd_valid}, 0);
      check("rd_wait_strobe", {31'b0, mem_valid}, 0);
      @(posedge clk); #1;
      check("rd_valid_3cyc", {31'b0, rd_valid}, 1);
      check("rd_data_7", rd_data, 32'h7);
      @(posedge clk); #1;
      check("rd_valid_pulse", {31'b0, rd_valid}, 0);
      check("rd_data_hold", rd_data, 32'h7);

      // 3. three auto writes from ptr 0
      send(1'b1, 1'b1, 8'hEE, 32'h10, 1'b0, 1'b1);
      check("auto0_ready_low", {31'b0, req_ready}, 0);
      send(1'b1, 1'b1, 8'hEE, 32'h11, 1'b0, 1'b1);
      check("auto1_ready_low", {31'b0, req_ready}, 0);
      send(1'b1, 1'b1, 8'hEE, 32'h12, 1'b0, 1'b1);
      check("auto2_ready_low", {31'b0, req_ready}, 0);
      @(posedge clk); #1;
      check("auto_ptr3", {24'b0, ptr}, 3);
      check("auto_mem0", mem[0], 32'h10);
      check("auto_mem1", mem[1], 32'h11);
      check("auto_mem2", mem[2], 32'h12);
      send(1'b0, 1'b0, 8'h01, 32'h0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);

      // 4. pointer wrap
      @(negedge clk);
      ptr_clr = 1'b1;
      ptr_m   = 8'h00;
      @(posedge clk); #1;
      ptr_clr = 1'b0;
      check("clr_idle_ptr", {24'b0, ptr}, 0);
      for (int i = 0; i < 255; i++)
         send(1'b1, 1'b1, 8'h00, i, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("ptr_ff", {24'b0, ptr}, 8'hFF);
      send(1'b1, 1'b1, 8'h00, 32'hABCD, 1'b0, 1'b1);
      check("wrap_addr", {24'b0, mem_addr}, 8'hFF);
      check("wrap_ptr", {24'b0, ptr}, 0);
      @(posedge clk); #1;
      check("wrap_mem_ff", mem[255], 32'hABCD);
      check("wrap_mem_c8", mem[200], 200);
      send(1'b0, 1'b0, 8'hFE, 32'h0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);

      // 5. reset during RD_REQ
      send(1'b0, 1'b0, 8'h04, 32'h0, 1'b0, 1'b0);
      check("abort_in_rdreq", {30'b0, state}, {30'b0, RD_REQ});
      reset = 1'b0;
      ptr_m = 8'h00;
      #1;
      check("abort_state", {30'b0, state}, {30'b0, IDLE});
      check("abort_mem_valid", {31'b0, mem_valid}, 0);
      check("abort_mem_addr", {24'b0, mem_addr}, 0);
      check("abort_ptr", {24'b0, ptr}, 0);
      check("abort_rd_data", rd_data, 0);
      check("abort_ready", {31'b0, req_ready}, 1);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_rdvalid", {31'b0, rd_valid}, 0);

      // 6. ptr_clr together with an accepted auto write at ptr 5
      for (int i = 0; i < 5; i++)
         send(1'b1, 1'b1, 8'h00, 32'h100 + i, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("pre_clr_ptr5", {24'b0, ptr}, 5);
      send(1'b1, 1'b1, 8'h33, 32'hC1C1, 1'b1, 1'b1);
      check("clr_acc_addr0", {24'b0, mem_addr}, 0);
      check("clr_acc_ptr1", {24'b0, ptr}, 1);
      // ptr_clr during the next write's strobe leaves that access alone
      send(1'b1, 1'b1, 8'h00, 32'hD2D2, 1'b0, 1'b1);
      ptr_clr = 1'b1;
      ptr_m   = 8'h00;
      @(posedge clk); #1;
      ptr_clr = 1'b0;
      check("inflight_addr", {24'b0, mem_addr}, 1);
      check("inflight_ptr", {24'b0, ptr}, 0);
      check("inflight_mem0", mem[0], 32'hC1C1);
      check("inflight_mem1", mem[1], 32'hD2D2);
      send(1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;

      // final report
      check("sb_drained", exp_q.size(), 0);
      check("no_strobe_overlap", overlap_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
